serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Bit-serial, multi-cycle subtractor: computes `diff = a - b - b_in` one bit per clock, LSB first, using a single borrow flip-flop.
- Complements the combinational ripple adders in the adders-and-buses block set: it is the subtract direction, traded for area instead of speed.
- Accepts operands on a start pulse, reports busy while shifting, then pulses done with a held result, borrow-out and signed-overflow flag.

## Interface
- `WIDTH`, default 4: operand/result width in bits; legal range 2–32.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: minuend; captured when start is accepted.
- `b` input WIDTH: subtrahend; captured when start is accepted.
- `b_in` input 1: borrow-in; captured when start is accepted.
- `busy` output 1: high during SHIFT.
- `done` output 1: one-cycle pulse; result valid.
- `diff` output WIDTH: difference, held until next accepted start.
- `b_out` output 1: final borrow, 1 when the unsigned result underflows.
- `ovf` output 1: signed (two's-complement) overflow.

## Operation
- FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE, start=1:**
  - load shift registers `sa <= a`, `sb <= b`;
  - set borrow register `br <= b_in`;
  - set bit counter `cnt <= 0`;
  - latch `a_msb <= a[WIDTH-1]`, `b_msb <= b[WIDTH-1]`;
  - go to SHIFT.
- **IDLE, start=0:** stay in IDLE; all outputs hold their values.
- **SHIFT, each cycle:**
  - `d = sa[0] ^ sb[0] ^ br`;
  - `br <= (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br)`;
  - shift `d` into the result register from the MSB side;
  - shift `sa` and `sb` right by one;
  - `cnt <= cnt+1`.
- **SHIFT exit:** on the cycle where `cnt == WIDTH-1`, go to DONE.
- **DONE (one cycle):**
  - `done=1`;
  - `diff` = result register;
  - `b_out = br`;
  - `ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`;
  - go to IDLE.
- **Output hold:** `diff`, `b_out` and `ovf` update only on entry to DONE and hold until the next DONE; they are not cleared by a new start.
- **start outside IDLE:** ignored in SHIFT and DONE, with no queuing. Operands are captured at start, so changes on `a`, `b`, `b_in` during SHIFT have no effect.
- **Arithmetic width:**
  - `diff` is `(a - b - b_in) mod 2^WIDTH`;
  - `b_out` = 1 iff `a < b + b_in` when treated as unsigned;
  - `cnt` width is `clog2(WIDTH)`, minimum 1.
- **Reset:**
  - `rst=1` in any state, including mid-SHIFT, returns to IDLE next edge and abandons any in-flight operation without asserting done;
  - the outputs `busy`, `done`, `diff`, `b_out`, `ovf` and all internal registers reset to 0;
  - rst has priority over start.

## Timing
- Start accepted at edge k:
  - busy high from cycle k+1 through k+WIDTH (WIDTH cycles);
  - done high for exactly one cycle, k+WIDTH+1.
- Latency: start-accept edge to done = WIDTH+1 cycles; 5 cycles for WIDTH=4.
- busy and done are never high together.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is accepted in the IDLE cycle following done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert rst for 2 cycles → busy=0, done=0, diff=0, b_out=0, ovf=0.
- **Basic subtract (WIDTH=4):** a=7, b=3, b_in=0, start pulse → busy for 4 cycles; done at cycle 5 with diff=4, b_out=0, ovf=0.
- **Unsigned underflow and borrow-in:**
  - a=3, b=7, b_in=0 → diff=0xC, b_out=1, ovf=0;
  - a=0, b=0, b_in=1 → diff=0xF, b_out=1, ovf=0.
- **Signed overflow:**
  - a=8 (−8), b=1 → diff=7, b_out=0, ovf=1;
  - a=7, b=0xF (−1) → diff=8, b_out=1, ovf=1.
- **Protocol:** change a/b and pulse start mid-SHIFT → ignored, original result returned. Start held high for 20 cycles → back-to-back operations with done every 6 cycles.
- **Reset mid-operation:** rst asserted at 2nd busy cycle → no done pulse, outputs 0. A new start afterwards (a=9, b=4) gives diff=5. Repeat the random a/b/b_in sweep at WIDTH=8 against a reference model.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor computing diff = a - b - b_in,
// one bit per clock, LSB first, using a single borrow flip-flop.
// A start pulse in IDLE captures the operands. busy stays high for WIDTH cycles.
// done then pulses for one cycle. diff, b_out and ovf hold until the next done.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_shifted;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             bit_d;
    logic             br_nxt;
    logic             last_bit;

    // One full-subtractor slice working on the current LSBs. The partial
    // result only keeps WIDTH-1 bits: the final bit joins it on the last
    // cycle, when the complete word is written straight into diff.
    assign bit_d       = sa[0] ^ sb[0] ^ br;
    assign br_nxt      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign res_shifted = {bit_d, res};
    assign last_bit    = (cnt == CW'(WIDTH - 1));

    // busy and done decode the state flops directly. They have no path from any input.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. start is only considered in IDLE, so it never queues.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then step one bit per SHIFT cycle
    // and publish the held outputs on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= b_in;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    br  <= br_nxt;
                    res <= res_shifted[WIDTH-1:1];
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        diff  <= res_shifted;
                        b_out <= br_nxt;
                        ovf   <= (a_msb != b_msb) && (bit_d != a_msb);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed WIDTH=4 vectors with hand-computed
// results, protocol corner cases, and a WIDTH=8 sweep against a behavioural model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       b_out;
    logic       ovf;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       b_in8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       b_out8;
    logic       ovf8;

    int compare_count  = 0;
    int mismatch_count = 0;
    int overlap_count  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       b_in;
        logic [3:0] exp_diff;
        logic       exp_b_out;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .b_in  (b_in8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .b_out (b_out8),
        .ovf   (ovf8)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // busy and done must never be high together on either instance
    always @(negedge clk) begin
        if ((busy && done) || (busy8 && done8)) overlap_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle with the given operands and wait for done.
    // lat counts cycles after the accepting edge (1 = first cycle after it).
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                                 output int busy_cycles, output int lat, output bit got_done);
        @(negedge clk);
        a = av; b = bv; b_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        lat = 0;
        got_done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         busy_cycles;
        int         lat;
        bit         got_done;
        int         done_hits;
        int         first_done;
        int         last_done;
        int         bad_gap;
        logic [7:0] av8;
        logic [7:0] bv8;
        logic       bi8;
        logic [8:0] full;
        int         sdiff;
        bit         got8;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; b_in8 = 1'b0;

        vecs[0] = '{4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0};
        vecs[1] = '{4'h3, 4'h7, 1'b0, 4'hC, 1'b1, 1'b0};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
        vecs[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};
        vecs[5] = '{4'h9, 4'h4, 1'b0, 4'h5, 1'b0, 1'b1};
        vecs[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[7] = '{4'h5, 4'h2, 1'b1, 4'h2, 1'b0, 1'b0};
        vecs[8] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0};
        vecs[9] = '{4'h8, 4'h0, 1'b1, 4'h7, 1'b0, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset diff", 32'(diff), 32'h0);
        checkOutput("reset b_out", 32'(b_out), 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'h0);

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].b_in, busy_cycles, lat, got_done);
            checkOutput($sformatf("vec%0d done seen", i), 32'(got_done), 32'h1);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd5);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(busy_cycles), 32'd4);
            checkOutput($sformatf("vec%0d diff", i), 32'(diff), 32'(vecs[i].exp_diff));
            checkOutput($sformatf("vec%0d b_out", i), 32'(b_out), 32'(vecs[i].exp_b_out));
            checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            @(negedge clk);
            checkOutput($sformatf("vec%0d done pulse width", i), 32'(done), 32'h0);
            checkOutput($sformatf("vec%0d diff hold", i), 32'(diff), 32'(vecs[i].exp_diff));
        end

        // Mid-SHIFT operand change and start pulse are ignored
        @(negedge clk);
        a = 4'h7; b = 4'h3; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'h0; b = 4'h0; b_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("midshift done seen", 32'(got_done), 32'h1);
        checkOutput("midshift diff", 32'(diff), 32'h4);
        checkOutput("midshift b_out", 32'(b_out), 32'h0);
        done_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        checkOutput("midshift no queued op", 32'(done_hits), 32'd0);

        // Start held high for 20 cycles: done every 6 cycles
        a = 4'h6; b = 4'h1; b_in = 1'b0; start = 1'b1;
        done_hits = 0; first_done = 0; last_done = 0; bad_gap = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                if (done_hits > 0 && (i - last_done) != 6) bad_gap++;
                if (done_hits == 0) first_done = i;
                last_done = i;
                done_hits++;
            end
        end
        start = 1'b0;
        checkOutput("held start done count", 32'(done_hits), 32'd3);
        checkOutput("held start first done", 32'(first_done), 32'd5);
        checkOutput("held start spacing errors", 32'(bad_gap), 32'd0);
        checkOutput("held start diff", 32'(diff), 32'h5);
        repeat (10) @(negedge clk);

        // Reset in the second busy cycle abandons the operation
        a = 4'h2; b = 4'h1; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre-reset busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midop reset busy", 32'(busy), 32'h0);
        checkOutput("midop reset diff", 32'(diff), 32'h0);
        checkOutput("midop reset b_out", 32'(b_out), 32'h0);
        checkOutput("midop reset ovf", 32'(ovf), 32'h0);
        done_hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_hits++;
            @(negedge clk);
        end
        checkOutput("midop reset no done", 32'(done_hits), 32'd0);
        applyStimulus(4'h9, 4'h4, 1'b0, busy_cycles, lat, got_done);
        checkOutput("post-reset done seen", 32'(got_done), 32'h1);
        checkOutput("post-reset diff", 32'(diff), 32'h5);

        // WIDTH=8 sweep against a behavioural model
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                av8 = 8'h80; bv8 = 8'h01; bi8 = 1'b0;
            end else if (i == 1) begin
                av8 = 8'h00; bv8 = 8'hFF; bi8 = 1'b1;
            end else begin
                av8 = 8'($urandom_range(0, 255));
                bv8 = 8'($urandom_range(0, 255));
                bi8 = 1'($urandom_range(0, 1));
            end
            full  = {1'b0, av8} - {1'b0, bv8} - {8'd0, bi8};
            sdiff = int'($signed(av8)) - int'($signed(bv8)) - int'(bi8);
            @(negedge clk);
            a8 = av8; b8 = bv8; b_in8 = bi8; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            got8 = 1'b0;
            lat = 0;
            for (int j = 1; j <= 30; j++) begin
                if (done8) begin
                    got8 = 1'b1;
                    lat = j;
                    break;
                end
                @(negedge clk);
            end
            checkOutput($sformatf("w8 vec%0d done seen", i), 32'(got8), 32'h1);
            checkOutput($sformatf("w8 vec%0d latency", i), 32'(lat), 32'd9);
            checkOutput($sformatf("w8 vec%0d diff", i), 32'(diff8), 32'(full[7:0]));
            checkOutput($sformatf("w8 vec%0d b_out", i), 32'(b_out8), 32'(full[8]));
            checkOutput($sformatf("w8 vec%0d ovf", i), 32'(ovf8),
                        32'((sdiff < -128) || (sdiff > 127)));
        end

        checkOutput("busy/done overlap", 32'(overlap_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
